// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-stage definitions: the default NOP instruction, the stage
// payload layouts, and the occupancy encoding of the elastic stage register.
package cpu_pipe_pkg;

    localparam int IR_W = 32;

    // Instruction word shown downstream for bubbles, flush and reset.
    localparam logic [IR_W-1:0] NOP_IR_DEF = 32'h0000_0000;

    // Occupancy encoding of the stage register.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        ONE   = ST_ONE,
        FULL  = ST_FULL
    } skid_state_e;

    // M/W stage payload: 5 x 32 = 160 bits.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic [31:0] ao;
        logic [31:0] dr;
    } mw_payload_t;

    // D/E and E/M stages carry PC, PC4, PC8 and the ALU result: 128 bits.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic [31:0] ao;
    } em_payload_t;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle between two pipeline stages and the stage register.
// master: the surrounding pipeline (drives upstream beats and downstream ready).
// slave:  the stage register itself.
interface pipe_skid_reg_if
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [IR_W-1:0]   in_ir;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [IR_W-1:0]   out_ir;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_ir, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ir, out_data
    );

    modport slave (
        input  in_valid, in_ir, in_data, flush, out_ready,
        output in_ready, out_valid, out_ir, out_data
    );
endinterface

// File: rtl/pipe_slot.sv
// One holding slot of the stage register: valid flag, instruction word and
// payload. Clear wins over load; a cleared slot shows NOP_IR but keeps its
// payload so out_data does not glitch when a bubble is inserted.
module pipe_slot
    import cpu_pipe_pkg::*;
#(
    parameter int              DATA_W = 128,
    parameter logic [IR_W-1:0] NOP_IR = NOP_IR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [IR_W-1:0]   i_ir,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [IR_W-1:0]   o_ir,
    output logic [DATA_W-1:0] o_data
);
    logic              r_valid;
    logic [IR_W-1:0]   r_ir;
    logic [DATA_W-1:0] r_data;

    // Slot register: clear kills the beat, load captures a new one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ir    <= NOP_IR;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ir    <= NOP_IR;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ir    <= i_ir;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ir    = r_ir;
    assign o_data  = r_data;
endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with valid/ready handshake and flush.
// Build option PIPE_SKID_EN: adds a skid slot so in_ready is a flop output
// (no combinational path from out_ready); otherwise a single slot with
// in_ready = !out_valid || out_ready.
//
// state | meaning
// EMPTY | main invalid, skid invalid
// ONE   | main valid,   skid invalid
// FULL  | main valid,   skid valid (upstream stalled)
module pipe_skid_reg
    import cpu_pipe_pkg::*;
#(
    parameter int              DATA_W = 128,
    parameter logic [IR_W-1:0] NOP_IR = NOP_IR_DEF
) (
    input  logic             clk,
    input  logic             reset,
    pipe_skid_reg_if.slave   bus
);
    logic              w_main_load;
    logic              w_main_clear;
    logic [IR_W-1:0]   w_main_ir_in;
    logic [DATA_W-1:0] w_main_data_in;
    logic              w_main_valid;
    logic [IR_W-1:0]   w_main_ir;
    logic [DATA_W-1:0] w_main_data;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_consume;

    pipe_slot #(
        .DATA_W (DATA_W),
        .NOP_IR (NOP_IR)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ir    (w_main_ir_in),
        .i_data  (w_main_data_in),
        .o_valid (w_main_valid),
        .o_ir    (w_main_ir),
        .o_data  (w_main_data)
    );

    assign w_accept  = bus.in_valid && w_in_ready;
    assign w_consume = w_main_valid && bus.out_ready;

`ifdef PIPE_SKID_EN
    skid_state_e       r_state;
    skid_state_e       w_state_nxt;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_sel_skid;
    logic              w_skid_valid;
    logic [IR_W-1:0]   w_skid_ir;
    logic [DATA_W-1:0] w_skid_data;

    pipe_slot #(
        .DATA_W (DATA_W),
        .NOP_IR (NOP_IR)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ir    (bus.in_ir),
        .i_data  (bus.in_data),
        .o_valid (w_skid_valid),
        .o_ir    (w_skid_ir),
        .o_data  (w_skid_data)
    );

    // Skid valid is itself a flop, so in_ready never sees out_ready directly.
    assign w_in_ready     = !w_skid_valid;
    assign w_main_ir_in   = w_sel_skid ? w_skid_ir   : bus.in_ir;
    assign w_main_data_in = w_sel_skid ? w_skid_data : bus.in_data;

    // Occupancy state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next occupancy and slot controls; flush overrides accept and consume.
    always_comb begin
        w_state_nxt  = r_state;
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_sel_skid   = 1'b0;
        if (bus.flush) begin
            w_state_nxt  = EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_consume) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = FULL;
                    end else if (w_consume) begin
                        w_main_clear = 1'b1;
                        w_state_nxt  = EMPTY;
                    end
                end
                FULL: begin
                    if (w_consume) begin
                        w_main_load  = 1'b1;
                        w_sel_skid   = 1'b1;
                        w_skid_clear = 1'b1;
                        w_state_nxt  = ONE;
                    end
                end
                default: begin
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                    w_state_nxt  = EMPTY;
                end
            endcase
        end
    end
`else
    // Single slot: a beat may enter on the same edge the held one leaves.
    assign w_in_ready     = !w_main_valid || bus.out_ready;
    assign w_main_ir_in   = bus.in_ir;
    assign w_main_data_in = bus.in_data;
    assign w_main_load    = w_accept;
    assign w_main_clear   = bus.flush || (w_consume && !w_accept);
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_main_valid;
    assign bus.out_ir    = w_main_ir;
    assign bus.out_data  = w_main_data;
endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;
    localparam int DW = 128;

    typedef struct {
        logic        iv;
        logic [31:0] ir;
        logic        fl;
        logic        ordy;
        logic        eov;
        logic [31:0] eir;
        logic        erdy;
    } vec_t;

    typedef struct {
        logic [31:0]   ir;
        logic [DW-1:0] data;
    } beat_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    beat_t         mq[$];
    logic [DW-1:0] m_last;
    vec_t          vecs[$];

    pipe_skid_reg_if #(.DATA_W(DW)) bus ();

    pipe_skid_reg #(.DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic iv, logic [31:0] ir, logic fl, logic ordy,
                                logic eov, logic [31:0] eir, logic erdy);
        vec_t v;
        v.iv = iv; v.ir = ir; v.fl = fl; v.ordy = ordy;
        v.eov = eov; v.eir = eir; v.erdy = erdy;
        return v;
    endfunction

    // Reference: a FIFO of held beats with capacity 2 (skid) or 1 (plain).
    function automatic bit m_ready(logic ordy);
`ifdef PIPE_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || ordy;
`endif
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_last = '0;
    endfunction

    function automatic void m_step();
        bit acc;
        bit con;
        beat_t b;
        if (reset) begin
            m_reset();
            return;
        end
        if (mq.size() > 0) m_last = mq[0].data;
        if (bus.flush) begin
            mq.delete();
        end else begin
            acc = bus.in_valid && m_ready(bus.out_ready);
            con = (mq.size() > 0) && bus.out_ready;
            if (con) void'(mq.pop_front());
            if (acc) begin
                b.ir = bus.in_ir;
                b.data = bus.in_data;
                mq.push_back(b);
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ir, input logic [DW-1:0] d,
                         input logic fl, input logic ordy);
        bus.in_valid  = iv;
        bus.in_ir     = ir;
        bus.in_data   = d;
        bus.flush     = fl;
        bus.out_ready = ordy;
    endtask

    task automatic run_cycle();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out_valid"}, DW'(bus.out_valid), DW'(mq.size() > 0));
        chk({tag, ".out_ir"}, DW'(bus.out_ir), DW'((mq.size() > 0) ? mq[0].ir : 32'h0));
        chk({tag, ".out_data"}, bus.out_data, (mq.size() > 0) ? mq[0].data : m_last);
        chk({tag, ".in_ready"}, DW'(bus.in_ready), DW'(m_ready(bus.out_ready)));
    endtask

    initial begin
        logic [DW-1:0] hold_d;
        n_cmp = 0;
        n_bad = 0;
        m_reset();
        drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst.in_ready_during", DW'(bus.in_ready), DW'(1));
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        m_step();
        #1;
        @(negedge clk);
        chk("rst.out_valid", DW'(bus.out_valid), DW'(0));
        chk("rst.out_ir", DW'(bus.out_ir), DW'(32'h0));
        chk("rst.out_data", bus.out_data, '0);
        chk("rst.in_ready", DW'(bus.in_ready), DW'(1));
        run_cycle();

        // streaming, common to both builds
        vecs.push_back(mk(1, 32'h1, 0, 1, 0, 32'h0, 1));
        vecs.push_back(mk(1, 32'h2, 0, 1, 1, 32'h1, 1));
        vecs.push_back(mk(1, 32'h3, 0, 1, 1, 32'h2, 1));
        vecs.push_back(mk(1, 32'h4, 0, 1, 1, 32'h3, 1));
        vecs.push_back(mk(0, 32'h0, 0, 1, 1, 32'h4, 1));
        vecs.push_back(mk(0, 32'h0, 0, 1, 0, 32'h0, 1));
`ifdef PIPE_SKID_EN
        vecs.push_back(mk(1, 32'h11, 0, 0, 0, 32'h0,  1));
        vecs.push_back(mk(1, 32'h22, 0, 0, 1, 32'h11, 1));
        vecs.push_back(mk(1, 32'h99, 0, 0, 1, 32'h11, 0));
        vecs.push_back(mk(0, 32'h0,  0, 1, 1, 32'h11, 0));
        vecs.push_back(mk(0, 32'h0,  0, 1, 1, 32'h22, 1));
        vecs.push_back(mk(0, 32'h0,  0, 1, 0, 32'h0,  1));
        vecs.push_back(mk(1, 32'h11, 0, 0, 0, 32'h0,  1));
        vecs.push_back(mk(1, 32'h22, 0, 0, 1, 32'h11, 1));
        vecs.push_back(mk(1, 32'h33, 1, 0, 1, 32'h11, 0));
        vecs.push_back(mk(0, 32'h0,  0, 1, 0, 32'h0,  1));
        vecs.push_back(mk(0, 32'h0,  0, 1, 0, 32'h0,  1));
        vecs.push_back(mk(1, 32'h55, 0, 0, 0, 32'h0,  1));
        vecs.push_back(mk(1, 32'h33, 1, 0, 1, 32'h55, 1));
        vecs.push_back(mk(0, 32'h0,  0, 1, 0, 32'h0,  1));
`else
        vecs.push_back(mk(1, 32'h11, 0, 0, 0, 32'h0,  1));
        vecs.push_back(mk(1, 32'h22, 0, 0, 1, 32'h11, 0));
        vecs.push_back(mk(1, 32'h22, 0, 1, 1, 32'h11, 1));
        vecs.push_back(mk(0, 32'h0,  0, 1, 1, 32'h22, 1));
        vecs.push_back(mk(0, 32'h0,  0, 1, 0, 32'h0,  1));
        vecs.push_back(mk(1, 32'h44, 0, 0, 0, 32'h0,  1));
        vecs.push_back(mk(1, 32'h33, 1, 1, 1, 32'h44, 1));
        vecs.push_back(mk(0, 32'h0,  0, 1, 0, 32'h0,  1));
        vecs.push_back(mk(0, 32'h0,  0, 1, 0, 32'h0,  1));
`endif
        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].ir, {4{vecs[i].ir}}, vecs[i].fl, vecs[i].ordy);
            @(negedge clk);
            chk($sformatf("vec%0d.out_valid", i), DW'(bus.out_valid), DW'(vecs[i].eov));
            chk($sformatf("vec%0d.out_ir", i), DW'(bus.out_ir), DW'(vecs[i].eir));
            chk($sformatf("vec%0d.in_ready", i), DW'(bus.in_ready), DW'(vecs[i].erdy));
            run_cycle();
        end

        // stall hold: held beat must not move while out_ready is low
        hold_d = {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_F00D};
        drive(1, 32'hABCD_0001, hold_d, 0, 1);
        run_cycle();
        for (int k = 0; k < 5; k++) begin
            drive(k[0] == 1'b0, $urandom, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
            @(negedge clk);
            chk($sformatf("stall%0d.out_valid", k), DW'(bus.out_valid), DW'(1));
            chk($sformatf("stall%0d.out_ir", k), DW'(bus.out_ir), DW'(32'hABCD_0001));
            chk($sformatf("stall%0d.out_data", k), bus.out_data, hold_d);
            run_cycle();
        end
        drive(0, 32'h0, '0, 1, 0);
        run_cycle();

        // reset while holding beats
        drive(1, 32'hA1, '1, 0, 0);
        run_cycle();
        drive(1, 32'hA2, '1, 0, 0);
        run_cycle();
        drive(0, 32'h0, '0, 0, 0);
        #2 reset = 1'b1;
        m_reset();
        #1;
        chk("midrst.out_valid", DW'(bus.out_valid), DW'(0));
        chk("midrst.out_ir", DW'(bus.out_ir), DW'(32'h0));
        chk("midrst.out_data", bus.out_data, '0);
        chk("midrst.in_ready", DW'(bus.in_ready), DW'(1));
        @(negedge clk);
        reset = 1'b0;
        drive(1, 32'h8C01_0004, {4{32'h5A5A_0004}}, 0, 1);
        run_cycle();
        drive(0, 32'h0, '0, 0, 1);
        @(negedge clk);
        chk("postrst.out_valid", DW'(bus.out_valid), DW'(1));
        chk("postrst.out_ir", DW'(bus.out_ir), DW'(32'h8C01_0004));
        chk("postrst.out_data", bus.out_data, {4{32'h5A5A_0004}});
        run_cycle();

        // randomized traffic against the FIFO model
        for (int c = 0; c < 3000; c++) begin
            int rp;
            rp = (c < 1000) ? 3 : ((c < 2000) ? 1 : 2);
            drive($urandom_range(0, 3) != 0, $urandom,
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 31) == 0,
                  $urandom_range(0, 3) < rp);
            @(negedge clk);
            chk_model($sformatf("rnd%0d", c));
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised, elastic pipeline-stage register. It is the successor to the fixed IR/PC/ALU-result stage latches.
- Carries one 32-bit instruction field plus a packed payload of DATA_W bits between two CPU stages.
- Uses a valid/ready handshake, a synchronous flush that inserts a NOP bubble, and an optional two-entry skid buffer.
- Sits between any two pipeline stages (D/E, E/M, M/W) and replaces the global en/stall latch.

Parameters:
- DATA_W, 128, payload width (e.g. PC, PC4, PC8, AO, DR packed = 160; default 128 for tests).
- NOP_IR, 32'h00000000, instruction value driven on out_ir for bubbles, flush and reset.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has a beat.
- in_ready  out  1  stage can accept a beat this cycle.
- in_ir  in  32  upstream instruction word.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  synchronous kill of all held beats.
- out_valid  out  1  out_ir/out_data hold a live beat.
- out_ready  in  1  downstream accepts this cycle.
- out_ir  out  32  held instruction; NOP_IR when out_valid=0.
- out_data  out  DATA_W  held payload.

Behaviour:
- Reset (async, immediate): out_valid=0, out_ir=NOP_IR, out_data=0, skid empty, in_ready=1 while and after reset.
- Handshake:
  - Accept when in_valid && in_ready at posedge.
  - Consume when out_valid && out_ready at posedge.
  - in_valid must not depend on in_ready.
- Latency: one cycle from accept to out_valid. Throughput is 1 beat/cycle when out_ready is held high.
- States (with PIPE_SKID_EN):
  - EMPTY (main invalid, skid invalid).
  - ONE (main valid, skid invalid).
  - FULL (main valid, skid valid).
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + consume -> ONE (main <= input).
  - ONE + accept + !consume -> FULL (skid <= input).
  - ONE + consume + !accept -> EMPTY.
  - FULL + consume -> ONE (main <= skid).
  - FULL: no accept possible.
- in_ready: registered, equal to !skid_valid, so there is no combinational path from out_ready to in_ready.
- Ordering: beats leave strictly in acceptance order. A skid beat always drains before any new beat.
- Flush:
  - At posedge, main and skid become invalid and out_ir=NOP_IR; out_data holds its old value.
  - Any beat accepted in the same cycle is discarded.
  - Flush has priority over accept and consume. The next state is EMPTY, with in_ready=1 the following cycle.
- While out_valid=0, out_ir always reads NOP_IR. Downstream decode therefore sees a bubble without gating.
- out_ir/out_data stay stable while out_valid && !out_ready.
- Reset asserted mid-transfer drops all beats. No partial update is visible.

Optional Feature:
- Macro: PIPE_SKID_EN.
- Defined:
  - Two-entry skid buffer as above.
  - in_ready is registered.
- Undefined:
  - Single register; no FULL state.
  - in_ready = !out_valid || out_ready (combinational).
  - Accept while consuming replaces main in the same edge.
- Flush, reset and NOP rules are identical in both builds.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - NOP_IR default constant.
  - Stage-payload typedefs (e.g. mw_payload_t packing PC/PC4/PC8/AO/DR, 160 bits).
  - State encoding localparams EMPTY/ONE/FULL.
- One sub-module is natural: pipe_slot, a single valid+ir+data register with load/clear. It is instantiated as main and skid.
- Control FSM stays in pipe_skid_reg.

Test Plan:
- Reset mid-stream: assert reset with state FULL -> out_valid=0, out_ir=0, in_ready=1 immediately. First beat after release (ir=0x8C010004) appears 1 cycle later.
- Streaming: in_valid=1, out_ready=1, ir=1,2,3,4 on consecutive cycles -> out_ir=1,2,3,4 on cycles 1..4; in_ready stays 1.
- Backpressure (skid build): out_ready=0 after beat A=0x11, send B=0x22 -> state FULL, in_ready=0 next cycle. out_ready=1 -> A, then B, in order; no loss.
- Flush priority: state FULL, flush=1 with in_valid=1 (ir=0x33) -> next cycle out_valid=0, out_ir=0, in_ready=1; 0x33 never appears.
- Stall hold: out_valid=1, out_ready=0 for 5 cycles with in_valid toggling -> out_ir/out_data unchanged every cycle.
- Non-skid build: repeat the streaming and backpressure tests -> in_ready follows out_ready combinationally and throughput stays 1 beat/cycle.
